// File: rtl/bcp_mem_pkg.sv
// Shared definitions for the BCP word memory: fill modes, FSM state type and
// the fill-value helper used by the init sequencer.
package bcp_mem_pkg;

  localparam int INIT_ZERO     = 0;
  localparam int INIT_IDENTITY = 1;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } mem_state_e;

  // Fill value for word idx; callers truncate to their data width, which
  // gives modulo-2**DATA_W wrap for identity fills deeper than the data range.
  function automatic logic [63:0] init_word(input int mode, input int unsigned idx);
    if (mode == INIT_IDENTITY) begin
      return 64'(idx);
    end
    return '0;
  endfunction

endpackage

// File: rtl/bcp_word_mem_if.sv
// Request/response bus of the BCP word memory, plus the init control pair.
interface bcp_word_mem_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);

  // A request transfers on every rising edge where req_valid && req_ready;
  // req_ready depends only on the memory's FSM state, never on req_valid.
  // Responses have no back-pressure: rsp_valid is a one-cycle pulse and
  // rsp_err qualifies it.
  logic              init_start;
  logic              init_busy;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output init_start, req_valid, req_write, req_addr, req_wdata,
    input  init_busy, req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  init_start, req_valid, req_write, req_addr, req_wdata,
    output init_busy, req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/bcp_word_mem_array.sv
// Single-port storage: synchronous write, registered read, no reset on the
// contents so it can map onto block RAM.
module bcp_word_mem_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clock,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // rdata only moves on a read, so it holds the last word read in between.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/bcp_word_mem.sv
// Parametrised BCP word memory: init sequencer FSM, range check and a
// 1- or 2-stage read response pipeline around a single-port array.
module bcp_word_mem
  import bcp_mem_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 8,
  parameter int INIT_MODE = 1,
  parameter int READ_LAT  = 1
) (
  input  logic         clock,
  input  logic         reset,
  bcp_word_mem_if.slave bus,
  output mem_state_e   state_dbg
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]   LAST_IDX  = AW'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_LIM = DEPTH[ADDR_W:0];

  mem_state_e        state;
  logic [AW-1:0]     ptr;
  logic              busy_q;
  logic              ready_q;

  logic              accept;
  logic              oor;
  logic              arr_we;
  logic              arr_re;
  logic [AW-1:0]     arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;
  logic [DATA_W-1:0] fill_word;

  logic              v1;
  logic              e1;

  assign accept    = bus.req_valid && ready_q;
  assign oor       = {1'b0, bus.req_addr} >= DEPTH_LIM;
  assign fill_word = DATA_W'(init_word(INIT_MODE, 32'(ptr)));

  // Sequencer owns the port during a fill; requests cannot be accepted then.
  always_comb begin
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_addr  = bus.req_addr[AW-1:0];
    arr_wdata = bus.req_wdata;
    if (state == INIT) begin
      arr_we    = 1'b1;
      arr_addr  = ptr;
      arr_wdata = fill_word;
    end else begin
      arr_we = accept && bus.req_write && !oor;
      arr_re = accept && !bus.req_write && !oor;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= INIT;
      ptr     <= '0;
      busy_q  <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (ptr == LAST_IDX) begin
            state   <= READY;
            ptr     <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            ptr <= ptr + AW'(1);
          end
        end
        READY: begin
          if (bus.init_start) begin
            state   <= INIT;
            ptr     <= '0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state   <= INIT;
          ptr     <= '0;
          busy_q  <= 1'b1;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  bcp_word_mem_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clock(clock),
    .we   (arr_we),
    .re   (arr_re),
    .addr (arr_addr),
    .wdata(arr_wdata),
    .rdata(arr_rdata)
  );

  // Stage 1 runs alongside the array's read register: reads and dropped
  // out-of-range writes both produce a response; good writes do not.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v1 <= 1'b0;
      e1 <= 1'b0;
    end else begin
      v1 <= accept && (!bus.req_write || oor);
      e1 <= accept && oor;
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              upd1;
      logic              v2;
      logic              e2;
      logic [DATA_W-1:0] rdata2;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          upd1   <= 1'b0;
          v2     <= 1'b0;
          e2     <= 1'b0;
          rdata2 <= '0;
        end else begin
          upd1 <= accept && !bus.req_write;
          v2   <= v1;
          e2   <= e1;
          if (upd1) begin
            rdata2 <= e1 ? '0 : arr_rdata;
          end
        end
      end

      assign bus.rsp_valid = v2;
      assign bus.rsp_err   = e2;
      assign bus.rsp_rdata = rdata2;
    end else begin : g_lat1
      // The array register holds the last good read; zero_q masks it after
      // an out-of-range read and from reset until the first good read.
      logic zero_q;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          zero_q <= 1'b1;
        end else if (accept && !bus.req_write) begin
          zero_q <= oor;
        end
      end

      assign bus.rsp_valid = v1;
      assign bus.rsp_err   = e1;
      assign bus.rsp_rdata = zero_q ? '0 : arr_rdata;
    end
  endgenerate

  assign bus.init_busy = busy_q;
  assign bus.req_ready = ready_q;
  assign state_dbg     = state;

endmodule
